// File: rtl/bus_nxm.sv
// Shared-bus interconnect: round-robin arbitration of N request/grant masters onto M
// memory-mapped slaves, one-hot decode, write broadcast and registered read return.
// Optional grant-hold limit compiled in with BUS_HOLD_LIMIT_EN.
module bus_nxm #(
  parameter int NUM_MASTERS = 2,
  parameter int NUM_SLAVES  = 2,
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int SLV_IDX_W   = 3,
  parameter int MAX_HOLD    = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_MASTERS-1:0]        M_req,
  input  logic [NUM_MASTERS-1:0]        M_wr,
  input  logic [NUM_MASTERS*ADDR_W-1:0] M_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0] M_dout,
  output logic [NUM_MASTERS-1:0]        M_grant,
  output logic [DATA_W-1:0]             M_din,
  output logic                          M_err,
  output logic [NUM_SLAVES-1:0]         S_sel,
  output logic                          S_wr,
  output logic [ADDR_W-1:0]             S_addr,
  output logic [DATA_W-1:0]             S_din,
  input  logic [NUM_SLAVES*DATA_W-1:0]  S_dout
);

  localparam int MST_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  // Illegal configurations elaborate this empty scope, which makes them easy to spot.
  if (NUM_MASTERS < 2 || NUM_SLAVES < 1 || SLV_IDX_W >= ADDR_W || MAX_HOLD < 1) begin : g_bad_params
  end

  // Owner register and round-robin pointer
  logic             owner_valid;
  logic [MST_W-1:0] owner_idx;
  logic [MST_W-1:0] rr_ptr;

  // Owner's request slice
  logic              own_req;
  logic              own_wr;
  logic [ADDR_W-1:0] own_addr;
  logic [DATA_W-1:0] own_dout;

  // Decode
  logic [SLV_IDX_W-1:0] idx;
  logic                 idx_ok;
  logic                 access;

  // Arbitration
  logic             keep;
  logic             preempt;
  logic             nxt_valid;
  logic [MST_W-1:0] nxt_idx;

  // Read return
  logic                 rd_valid;
  logic [SLV_IDX_W-1:0] rd_idx;

  // NOTE: every signal written in an always_comb gets a default first, so no path
  // through the block can leave it unassigned and infer a latch.
  always_comb begin
    own_req  = 1'b0;
    own_wr   = 1'b0;
    own_addr = '0;
    own_dout = '0;
    M_grant  = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (owner_valid && owner_idx == MST_W'(i)) begin
        own_req    = M_req[i];
        own_wr     = M_wr[i];
        own_addr   = M_addr[i*ADDR_W +: ADDR_W];
        own_dout   = M_dout[i*DATA_W +: DATA_W];
        M_grant[i] = 1'b1;
      end
    end
  end

  assign idx    = own_addr[ADDR_W-1 -: SLV_IDX_W];
  assign idx_ok = 32'(idx) < NUM_SLAVES;
  assign access = owner_valid && own_req;

  assign S_addr = own_addr;
  assign S_din  = own_dout;
  assign S_wr   = access && idx_ok && own_wr;

  always_comb begin
    S_sel = '0;
    for (int s = 0; s < NUM_SLAVES; s++) begin
      S_sel[s] = access && idx_ok && (idx == SLV_IDX_W'(s));
    end
  end

`ifdef BUS_HOLD_LIMIT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  logic [HOLD_W-1:0] hold_cnt;
  logic              others_req;

  assign others_req = |(M_req & ~M_grant);
  assign preempt    = owner_valid && (32'(hold_cnt) >= MAX_HOLD) && others_req;

  // Counts granted cycles of the current owner; saturates when nobody else is waiting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_cnt <= '0;
    end else if (!nxt_valid) begin
      hold_cnt <= '0;
    end else if (!keep) begin
      hold_cnt <= HOLD_W'(1);
    end else if (32'(hold_cnt) < MAX_HOLD) begin
      hold_cnt <= hold_cnt + HOLD_W'(1);
    end
  end
`else
  assign preempt = 1'b0;
`endif

  assign keep = access && !preempt;

  // Scan order starts one past the last owner and wraps, so the last owner goes last.
  always_comb begin
    nxt_valid = 1'b0;
    nxt_idx   = owner_idx;
    if (keep) begin
      nxt_valid = 1'b1;
    end else begin
      for (int k = 1; k <= NUM_MASTERS; k++) begin
        for (int j = 0; j < NUM_MASTERS; j++) begin
          if (!nxt_valid && M_req[j] && j == (int'(rr_ptr) + k) % NUM_MASTERS) begin
            nxt_valid = 1'b1;
            nxt_idx   = MST_W'(j);
          end
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner_valid <= 1'b0;
      owner_idx   <= '0;
      rr_ptr      <= '0;
    end else begin
      owner_valid <= nxt_valid;
      owner_idx   <= nxt_idx;
      if (nxt_valid) begin
        rr_ptr <= nxt_idx;
      end
    end
  end

  // Slaves answer one cycle after select; remember which one to mux back.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid <= 1'b0;
      rd_idx   <= '0;
      M_err    <= 1'b0;
    end else begin
      rd_valid <= (|S_sel) && !S_wr;
      rd_idx   <= idx;
      M_err    <= access && !idx_ok;
    end
  end

  always_comb begin
    M_din = '0;
    for (int s = 0; s < NUM_SLAVES; s++) begin
      if (rd_valid && rd_idx == SLV_IDX_W'(s)) begin
        M_din = S_dout[s*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: tb/tb_bus_nxm.sv
// Directed self-checking bench for bus_nxm with two synchronous RAM slave models.
// Covers the hold-limit path when built with BUS_HOLD_LIMIT_EN.
module tb_bus_nxm;

  localparam int NM = 2;
  localparam int NS = 2;
  localparam int AW = 8;
  localparam int DW = 32;

  logic              clk;
  logic              reset_n;
  logic [NM-1:0]     M_req;
  logic [NM-1:0]     M_wr;
  logic [NM*AW-1:0]  M_addr;
  logic [NM*DW-1:0]  M_dout;
  logic [NM-1:0]     M_grant;
  logic [DW-1:0]     M_din;
  logic              M_err;
  logic [NS-1:0]     S_sel;
  logic              S_wr;
  logic [AW-1:0]     S_addr;
  logic [DW-1:0]     S_din;
  logic [NS*DW-1:0]  S_dout;

  int checks;
  int failures;

  bus_nxm #(
    .NUM_MASTERS(NM), .NUM_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW),
    .SLV_IDX_W(3), .MAX_HOLD(4)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .M_req(M_req), .M_wr(M_wr), .M_addr(M_addr), .M_dout(M_dout),
    .M_grant(M_grant), .M_din(M_din), .M_err(M_err),
    .S_sel(S_sel), .S_wr(S_wr), .S_addr(S_addr), .S_din(S_din), .S_dout(S_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM slaves: slave 0 at 0x00-0x1F, slave 1 at 0x20-0x3F.
  logic [DW-1:0] mem0 [32];
  logic [DW-1:0] mem1 [32];
  logic [DW-1:0] sdo0, sdo1;
  assign S_dout = {sdo1, sdo0};

  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) begin
        mem0[i] <= '0;
        mem1[i] <= 32'h5000_0000 + i;
      end
      sdo0 <= '0;
      sdo1 <= '0;
    end else begin
      if (S_sel[0]) begin
        if (S_wr) mem0[S_addr[4:0]] <= S_din;
        else      sdo0 <= mem0[S_addr[4:0]];
      end
      if (S_sel[1]) begin
        if (S_wr) mem1[S_addr[4:0]] <= S_din;
        else      sdo1 <= mem1[S_addr[4:0]];
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int i, input logic req, input logic wr,
                       input logic [AW-1:0] addr, input logic [DW-1:0] dout);
    M_req[i]             = req;
    M_wr[i]              = wr;
    M_addr[i*AW +: AW]   = addr;
    M_dout[i*DW +: DW]   = dout;
  endtask

  logic [NM-1:0] exp_grant;

  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    M_req    = '0;
    M_wr     = '0;
    M_addr   = '0;
    M_dout   = '0;
    tick();
    tick();

    // Reset state
    check("rst_grant", M_grant, 0);
    check("rst_sel",   S_sel,   0);
    check("rst_wr",    S_wr,    0);
    check("rst_addr",  S_addr,  0);
    check("rst_sdin",  S_din,   0);
    check("rst_mdin",  M_din,   0);
    check("rst_err",   M_err,   0);
    reset_n = 1'b1;

    // Master 0 write
    set_m(0, 1'b1, 1'b1, 8'h05, 32'hDEAD_BEEF);
    #1;
    check("grant_latency", M_grant, 0);
    tick();
    check("wr_grant", M_grant, 2'b01);
    check("wr_sel",   S_sel,   2'b01);
    check("wr_strb",  S_wr,    1);
    check("wr_addr",  S_addr,  8'h05);
    check("wr_data",  S_din,   32'hDEAD_BEEF);

    // Master 0 reads the word back
    tick();
    set_m(0, 1'b1, 1'b0, 8'h05, 32'h0);
    #1;
    check("rd_sel",        S_sel, 2'b01);
    check("rd_wr_low",     S_wr,  0);
    check("din_after_wr",  M_din, 0);
    tick();
    check("rd_data",       M_din, 32'hDEAD_BEEF);
    set_m(0, 1'b0, 1'b0, 8'h05, 32'h0);
    tick();
    check("rd_data_clear", M_din, 0);
    check("release_grant", M_grant, 0);

    // Alternating grants with one-cycle request drops
    set_m(0, 1'b1, 1'b0, 8'h00, 32'h0);
    set_m(1, 1'b1, 1'b0, 8'h21, 32'h0);
    tick();
    exp_grant = 2'b10;
    for (int n = 0; n < 6; n++) begin
      check("alt_grant",  M_grant, exp_grant);
      check("alt_onehot", $countones(M_grant) <= 1, 1);
      M_req = ~exp_grant;
      tick();
      exp_grant = ~exp_grant;
    end
    check("alt_grant_last", M_grant, exp_grant);
    M_req = '0;
    tick();
    check("alt_idle", M_grant, 0);

    // Decode error: idx 7 with two slaves
    set_m(0, 1'b1, 1'b0, 8'hE0, 32'h0);
    tick();
    check("derr_grant", M_grant, 2'b01);
    check("derr_sel",   S_sel,   0);
    check("derr_wr",    S_wr,    0);
    check("derr_early", M_err,   0);
    tick();
    check("derr_pulse", M_err,   1);
    check("derr_din",   M_din,   0);
    set_m(0, 1'b0, 1'b0, 8'h00, 32'h0);
    tick();
    check("derr_clear", M_err,   0);

    // Back-to-back reads from slave 1
    set_m(1, 1'b1, 1'b0, 8'h20, 32'h0);
    tick();
    check("b2b_grant", M_grant, 2'b10);
    check("b2b_sel",   S_sel,   2'b10);
    tick();
    set_m(1, 1'b1, 1'b0, 8'h21, 32'h0);
    check("b2b_w0", M_din, 32'h5000_0000);
    tick();
    set_m(1, 1'b1, 1'b0, 8'h22, 32'h0);
    check("b2b_w1", M_din, 32'h5000_0001);
    tick();
    set_m(1, 1'b0, 1'b0, 8'h00, 32'h0);
    check("b2b_w2", M_din, 32'h5000_0002);
    tick();
    check("b2b_end", M_din, 0);

    // Reset asserted in the middle of a granted write
    set_m(0, 1'b1, 1'b1, 8'h06, 32'h1234_5678);
    tick();
    check("mid_wr",    S_wr, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_grant", M_grant, 0);
    check("mid_rst_wr",    S_wr,    0);
    check("mid_rst_sel",   S_sel,   0);
    check("mid_rst_addr",  S_addr,  0);
    tick();
    set_m(0, 1'b0, 1'b0, 8'h00, 32'h0);
    reset_n = 1'b1;
    tick();
    check("post_rst_wr",    S_wr,    0);
    check("post_rst_grant", M_grant, 0);

    // Simultaneous requests after reset: master 1 scanned first
    M_req = 2'b11;
    tick();
    check("prio_after_rst", M_grant, 2'b10);
    M_req = '0;
    tick();

    // Grant hold behaviour
    M_req = 2'b01;
    tick();
    check("hold_first", M_grant, 2'b01);
    M_req = 2'b11;
`ifdef BUS_HOLD_LIMIT_EN
    for (int n = 0; n < 3; n++) begin
      tick();
      check("hold_keep", M_grant, 2'b01);
    end
    tick();
    check("hold_preempt", M_grant, 2'b10);
    M_req = 2'b10;
    for (int n = 0; n < 6; n++) begin
      tick();
      check("hold_saturate", M_grant, 2'b10);
    end
`else
    for (int n = 0; n < 8; n++) begin
      tick();
      check("hold_forever", M_grant, 2'b01);
    end
`endif
    M_req = '0;
    tick();
    check("final_idle", M_grant, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
